agu_rs_pipe: RTL

Parametrised address-generation reservation-station array with a pipelined AGU, a registered CDB result port and oldest-first issue. It sits between dispatch and the load/store queue, in place of the single-cycle AGU station group. It adds the following:
- CDB operand wakeup with same-cycle bypass at allocation.
- Age-ordered selection.
- Configurable AGU latency.
- A valid/grant handshake toward the CDB arbiter.
- Full flush.

---
 rtl/lc3b_types.sv | 25 ++
 rtl/agu_pipe.sv | 68 ++++++
 rtl/agu_rs_pipe.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the AGU reservation station: address modes,
// decoding of the op field and default sizing of the station group.
package lc3b_types;

  localparam int NUM_AGU_STATIONS = 4;
  localparam int AGU_LATENCY_DFLT = 1;

  typedef enum logic [1:0] {
    AGU_BYTE = 2'b00,
    AGU_WORD = 2'b01,
    AGU_ABS  = 2'b10
  } agu_mode_e;

  // The reserved encoding 2'b11 behaves as a byte-mode add.
  function automatic agu_mode_e agu_mode_decode(input logic [1:0] op_mode);
    agu_mode_e mode;
    case (op_mode)
      2'b01:   mode = AGU_WORD;
      2'b10:   mode = AGU_ABS;
      default: mode = AGU_BYTE;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/agu_pipe.sv
// AGU datapath: mode arithmetic followed by LATENCY stage registers that
// advance together; the last stage feeds the station's output register.
module agu_pipe
  import lc3b_types::*;
#(
  parameter int LATENCY  = 1,
  parameter int WORD_W   = 16,
  parameter int ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                advance,
  input  logic                in_valid,
  input  agu_mode_e           in_mode,
  input  logic [WORD_W-1:0]   in_vj,
  input  logic [WORD_W-1:0]   in_vk,
  input  logic [ROB_ID_W-1:0] in_dest,
  output logic                last_valid,
  output logic [ROB_ID_W-1:0] last_dest,
  output logic [WORD_W-1:0]   last_addr
);

  logic [WORD_W-1:0]   addr_s;
  logic                stg_valid_r [LATENCY];
  logic [ROB_ID_W-1:0] stg_dest_r  [LATENCY];
  logic [WORD_W-1:0]   stg_addr_r  [LATENCY];

  // Address arithmetic, wrapping modulo 2^WORD_W.
  always_comb begin
    addr_s = '0;
    case (in_mode)
      AGU_BYTE: addr_s = in_vj + in_vk;
      AGU_WORD: addr_s = in_vj + {in_vk[WORD_W-2:0], 1'b0};
      AGU_ABS:  addr_s = in_vk;
      default:  addr_s = in_vj + in_vk;
    endcase
  end

  // Stage registers: flush kills every stage, otherwise shift as one block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LATENCY; s++) begin
        stg_valid_r[s] <= 1'b0;
        stg_dest_r[s]  <= '0;
        stg_addr_r[s]  <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < LATENCY; s++) begin
        stg_valid_r[s] <= 1'b0;
      end
    end else if (advance) begin
      stg_valid_r[0] <= in_valid;
      stg_dest_r[0]  <= in_dest;
      stg_addr_r[0]  <= addr_s;
      for (int s = 1; s < LATENCY; s++) begin
        stg_valid_r[s] <= stg_valid_r[s-1];
        stg_dest_r[s]  <= stg_dest_r[s-1];
        stg_addr_r[s]  <= stg_addr_r[s-1];
      end
    end
  end

  assign last_valid = stg_valid_r[LATENCY-1];
  assign last_dest  = stg_dest_r[LATENCY-1];
  assign last_addr  = stg_addr_r[LATENCY-1];

endmodule

// File: rtl/agu_rs_pipe.sv
// AGU reservation-station array: CDB wakeup with allocation bypass,
// oldest-first issue into a pipelined AGU and a granted output register.
module agu_rs_pipe
  import lc3b_types::*;
#(
  parameter int NUM_STATIONS = NUM_AGU_STATIONS,
  parameter int AGU_LATENCY  = AGU_LATENCY_DFLT,
  parameter int WORD_W       = 16,
  parameter int ROB_ID_W     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               alloc_valid,
  output logic                               alloc_ready,
  input  logic [3:0]                         alloc_op,
  input  logic [WORD_W-1:0]                  alloc_vj,
  input  logic [WORD_W-1:0]                  alloc_vk,
  input  logic [ROB_ID_W-1:0]                alloc_qj,
  input  logic [ROB_ID_W-1:0]                alloc_qk,
  input  logic                               alloc_qj_pend,
  input  logic                               alloc_qk_pend,
  input  logic [ROB_ID_W-1:0]                alloc_dest,
  input  logic                               cdb_valid,
  input  logic [ROB_ID_W-1:0]                cdb_dest,
  input  logic [WORD_W-1:0]                  cdb_value,
  output logic                               out_valid,
  input  logic                               out_grant,
  output logic [ROB_ID_W-1:0]                out_dest,
  output logic [WORD_W-1:0]                  out_addr,
  output logic [$clog2(NUM_STATIONS+1)-1:0]  free_count
);

  localparam int CNT_W = $clog2(NUM_STATIONS + 1);
  localparam int IDX_W = $clog2(NUM_STATIONS);
  localparam int AGE_W = IDX_W;

  typedef struct packed {
    logic                valid;
    logic [3:0]          op;
    logic [WORD_W-1:0]   vj;
    logic [WORD_W-1:0]   vk;
    logic [ROB_ID_W-1:0] qj;
    logic [ROB_ID_W-1:0] qk;
    logic                pend_j;
    logic                pend_k;
    logic [ROB_ID_W-1:0] dest;
    logic [AGE_W-1:0]    age;
  } lc3b_agu_rs_entry;

  lc3b_agu_rs_entry        ent_r     [NUM_STATIONS];
  lc3b_agu_rs_entry        ent_nxt_s [NUM_STATIONS];
  lc3b_agu_rs_entry        new_ent_s;
  logic [NUM_STATIONS-1:0] ready_s;
  logic [NUM_STATIONS-1:0] wake_j_s;
  logic [NUM_STATIONS-1:0] wake_k_s;
  logic                    sel_found_s;
  logic [IDX_W-1:0]        sel_idx_s;
  logic [AGE_W-1:0]        sel_age_s;
  logic [3:0]              iss_op_s;
  logic [WORD_W-1:0]       iss_vj_s;
  logic [WORD_W-1:0]       iss_vk_s;
  logic [ROB_ID_W-1:0]     iss_dest_s;
  agu_mode_e               iss_mode_s;
  logic [IDX_W-1:0]        free_idx_s;
  logic [CNT_W-1:0]        valid_cnt_s;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic                    issue_s;
  logic                    advance_s;
  logic                    alloc_fire_s;
  logic                    byp_j_s;
  logic                    byp_k_s;
  logic                    last_valid_s;
  logic [ROB_ID_W-1:0]     last_dest_s;
  logic [WORD_W-1:0]       last_addr_s;
  logic                    out_valid_r;
  logic [ROB_ID_W-1:0]     out_dest_r;
  logic [WORD_W-1:0]       out_addr_r;
  logic [CNT_W-1:0]        free_count_r;
  logic                    alloc_ready_r;

  // A held result blocks the pipe only when a finished result waits behind it.
  assign advance_s    = !(out_valid_r && !out_grant && last_valid_s);
  assign issue_s      = sel_found_s && advance_s && !flush;
  assign alloc_fire_s = alloc_valid && alloc_ready_r && !flush;
  assign byp_j_s      = cdb_valid && alloc_qj_pend && (cdb_dest == alloc_qj);
  assign byp_k_s      = cdb_valid && alloc_qk_pend && (cdb_dest == alloc_qk);
  assign iss_mode_s   = agu_mode_decode(iss_op_s[1:0]);

  // Readiness, occupancy and free-slot search on registered entry state.
  always_comb begin
    ready_s     = '0;
    valid_cnt_s = '0;
    free_idx_s  = '0;
    for (int i = NUM_STATIONS - 1; i >= 0; i--) begin
      ready_s[i]  = ent_r[i].valid && !ent_r[i].pend_j && !ent_r[i].pend_k;
      valid_cnt_s = valid_cnt_s + CNT_W'(ent_r[i].valid);
      if (!ent_r[i].valid) begin
        free_idx_s = IDX_W'(i);
      end else begin
        free_idx_s = free_idx_s;
      end
    end
  end

  // Oldest-first select: ages are unique, so the minimum is unambiguous.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    sel_age_s   = '0;
    iss_op_s    = '0;
    iss_vj_s    = '0;
    iss_vk_s    = '0;
    iss_dest_s  = '0;
    for (int i = 0; i < NUM_STATIONS; i++) begin
      if (ready_s[i] && (!sel_found_s || ent_r[i].age < sel_age_s)) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IDX_W'(i);
        sel_age_s   = ent_r[i].age;
        iss_op_s    = ent_r[i].op;
        iss_vj_s    = ent_r[i].vj;
        iss_vk_s    = ent_r[i].vk;
        iss_dest_s  = ent_r[i].dest;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Incoming entry, with same-cycle CDB capture for each pending operand.
  always_comb begin
    new_ent_s        = '0;
    new_ent_s.valid  = 1'b1;
    new_ent_s.op     = alloc_op;
    new_ent_s.vj     = byp_j_s ? cdb_value : alloc_vj;
    new_ent_s.vk     = byp_k_s ? cdb_value : alloc_vk;
    new_ent_s.qj     = alloc_qj;
    new_ent_s.qk     = alloc_qk;
    new_ent_s.pend_j = alloc_qj_pend && !byp_j_s;
    new_ent_s.pend_k = alloc_qk_pend && !byp_k_s;
    new_ent_s.dest   = alloc_dest;
    new_ent_s.age    = AGE_W'(valid_cnt_s - CNT_W'(issue_s));
  end

  // Next entry state: allocate, issue, age compaction, wakeup and flush.
  always_comb begin
    cnt_nxt_s = '0;
    wake_j_s  = '0;
    wake_k_s  = '0;
    for (int i = 0; i < NUM_STATIONS; i++) begin
      wake_j_s[i] = cdb_valid && ent_r[i].valid && ent_r[i].pend_j && (ent_r[i].qj == cdb_dest);
      wake_k_s[i] = cdb_valid && ent_r[i].valid && ent_r[i].pend_k && (ent_r[i].qk == cdb_dest);
      ent_nxt_s[i] = ent_r[i];
      if (alloc_fire_s && (free_idx_s == IDX_W'(i))) begin
        ent_nxt_s[i] = new_ent_s;
      end else if (issue_s && (sel_idx_s == IDX_W'(i))) begin
        ent_nxt_s[i].valid = 1'b0;
      end else begin
        ent_nxt_s[i].vj     = wake_j_s[i] ? cdb_value : ent_r[i].vj;
        ent_nxt_s[i].vk     = wake_k_s[i] ? cdb_value : ent_r[i].vk;
        ent_nxt_s[i].pend_j = ent_r[i].pend_j && !wake_j_s[i];
        ent_nxt_s[i].pend_k = ent_r[i].pend_k && !wake_k_s[i];
        ent_nxt_s[i].age    = (issue_s && ent_r[i].valid && (ent_r[i].age > sel_age_s)) ?
                              ent_r[i].age - AGE_W'(1) : ent_r[i].age;
      end
      ent_nxt_s[i].valid = ent_nxt_s[i].valid && !flush;
      cnt_nxt_s = cnt_nxt_s + CNT_W'(ent_nxt_s[i].valid);
    end
  end

  // Entry array plus the occupancy view seen by dispatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STATIONS; i++) begin
        ent_r[i] <= '0;
      end
      free_count_r  <= CNT_W'(NUM_STATIONS);
      alloc_ready_r <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_STATIONS; i++) begin
        ent_r[i] <= ent_nxt_s[i];
      end
      free_count_r  <= CNT_W'(NUM_STATIONS) - cnt_nxt_s;
      alloc_ready_r <= (cnt_nxt_s != CNT_W'(NUM_STATIONS));
    end
  end

  agu_pipe #(
    .LATENCY  (AGU_LATENCY),
    .WORD_W   (WORD_W),
    .ROB_ID_W (ROB_ID_W)
  ) u_agu_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .advance    (advance_s),
    .in_valid   (issue_s),
    .in_mode    (iss_mode_s),
    .in_vj      (iss_vj_s),
    .in_vk      (iss_vk_s),
    .in_dest    (iss_dest_s),
    .last_valid (last_valid_s),
    .last_dest  (last_dest_s),
    .last_addr  (last_addr_s)
  );

  // Output register: reload when empty or granted; flush wins over a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_dest_r  <= '0;
      out_addr_r  <= '0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (!out_valid_r || out_grant) begin
      out_valid_r <= last_valid_s;
      if (last_valid_s) begin
        out_dest_r <= last_dest_s;
        out_addr_r <= last_addr_s;
      end
    end
  end

  assign out_valid   = out_valid_r;
  assign out_dest    = out_dest_r;
  assign out_addr    = out_addr_r;
  assign free_count  = free_count_r;
  assign alloc_ready = alloc_ready_r;

endmodule
